alu_seq_nb: RTL and testbench
=============================

ALU_SEQ_NB -- requirements
Module: alu_seq_nb

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  operand/opcode presented.
REQ-005 Port: in_ready  output  1  block accepts a new operation.
REQ-006 Port: a  input  WIDTH  operand A, unsigned.
REQ-007 Port: b  input  WIDTH  operand B, unsigned.
REQ-008 Port: op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: result  output  2*WIDTH  sum/difference/product/quotient, zero-extended.
REQ-012 Port: rem  output  WIDTH  DIV remainder; 0 for other ops.
REQ-013 Port: carry  output  1  ADD carry-out / SUB borrow; 0 for MUL/DIV.
REQ-014 Port: zero  output  1  result == 0.
REQ-015 Port: err  output  1  DIV with b == 0.

Function
REQ-016 FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-017 Accept when in_valid && in_ready; a, b, op registered; later input changes ignored.
REQ-018 ADD/SUB: IDLE -> DONE; out_valid high the cycle after acceptance (latency 1).
REQ-019 ADD: result = a + b with bit WIDTH = carry-out; carry = that bit.
REQ-020 SUB: result = (a - b) mod 2^WIDTH, upper bits 0; carry = 1 iff a < b.
REQ-021 MUL: shift-add, one bit per cycle; IDLE -> CALC for exactly WIDTH cycles -> DONE; latency WIDTH+1; result = full 2*WIDTH product.
REQ-022 DIV: restoring, one quotient bit per cycle, same WIDTH+1 latency; result = quotient, rem = remainder.
REQ-023 DIV with b == 0: skip CALC, latency 1; result = all ones in low WIDTH bits, upper bits 0; rem = a; err = 1.
REQ-024 DONE: out_valid = 1; result/rem/flags held stable until out_ready; on out_valid && out_ready -> IDLE.
REQ-025 No acceptance in the cycle DONE is left; minimum initiation interval is latency + 1.
REQ-026 Output registers change only on DONE entry; hold last values in IDLE/CALC.
REQ-027 Iteration counter: ceil(log2(WIDTH+1)) bits, loaded with WIDTH on entry to CALC, decremented each CALC cycle, exit at 1.

Reset
REQ-028 rst_n low: state = IDLE; out_valid, result, rem, carry, err = 0; zero = 1; counter and operand registers = 0.
REQ-029 Reset asserted mid-CALC or in DONE aborts the operation; no out_valid follows it.

Configuration
REQ-030 Macro ALU_SEVSEG_EN defined: adds outputs disp1op, disp0op (7 bits each, gfedcba, active-high) showing result[7:4] and result[3:0] as hex 0-F, registered with result, reset to the "0" glyph.
REQ-031 ALU_SEVSEG_EN undefined: those ports and the decoders are absent; all other behaviour identical.

Structure
REQ-032 Package alu_seq_pkg holds op encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the FSM state encoding.
REQ-033 One sub-module seg7_dec (4-bit hex -> 7-segment, combinational), instantiated twice only under ALU_SEVSEG_EN.

Verification (WIDTH=4)
REQ-034 ADD a=15 b=1, out_ready=1 -> out_valid 1 cycle after accept, result=0x10, carry=1, zero=0.
REQ-035 SUB a=3 b=6 -> result=0x0D, carry=1; SUB a=5 b=5 -> result=0, zero=1, carry=0.
REQ-036 MUL a=15 b=15 -> out_valid exactly 5 cycles after accept, result=0xE1; DIV a=14 b=4 -> result=3, rem=2, 5 cycles.
REQ-037 DIV a=9 b=0 -> latency 1, result=0x0F, rem=9, err=1.
REQ-038 MUL 7*9 with out_ready low 3 cycles -> result=0x3F stable, in_ready=0 throughout; IDLE after out_ready.
REQ-039 rst_n low 2 cycles into MUL -> out_valid never asserts, in_ready=1 after release, all outputs at reset values.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the sequential ALU. Holds the opcode
//               encodings and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_dec.sv
`default_nettype none
// ============================================================================
// Module      : seg7_dec
// Description : Combinational hex digit to 7-segment decoder.
//               Segment order gfedcba, active-high.
// Ports       : hex_i  [3:0]  nibble to display (0-F)
//               seg_o  [6:0]  segment pattern {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_dec (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    case (hex_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      default: seg_o = 7'h71;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq_nb.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_nb
// Description : Sequential unsigned ALU with valid/ready handshake.
//               ADD/SUB and DIV-by-zero complete in 1 cycle; MUL (shift-add)
//               and DIV (restoring) iterate one bit per cycle for WIDTH cycles.
// Parameters  : WIDTH (2..32) operand width
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready, a, b, op   - operation request
//               out_valid/out_ready           - result handshake
//               result [2*WIDTH], rem [WIDTH], carry, zero, err
//               disp1op/disp0op [7] (only with ALU_SEVSEG_EN) - hex display
//               of result[7:4] / result[3:0]
// Macro       : ALU_SEVSEG_EN enables the 7-segment display outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_nb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     rem,
  output logic                 carry,
  output logic                 zero,
  output logic                 err
`ifdef ALU_SEVSEG_EN
  ,
  output logic [6:0]           disp1op,
  output logic [6:0]           disp0op
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     b_q, b_d;
  // Working register: MUL {partial product hi, multiplier/low product},
  // DIV {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;
  logic                 w_load;

  // Single-cycle operations
  logic [WIDTH:0]       w_add, w_sub;
  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};   // bit WIDTH is the borrow

  // One shift-add multiply step
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step. The partial remainder is always below b, so
  // the shifted value is below 2*b and a non-negative trial difference never
  // sets bit WIDTH: that bit is therefore a pure borrow flag.
  logic [WIDTH:0]       w_div_shift, w_div_trial;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_rem;
  logic [2*WIDTH-1:0]   w_div_next;
  assign w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, b_q};
  assign w_div_ge    = ~w_div_trial[WIDTH];
  assign w_div_rem   = w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_next  = {w_div_rem, acc_q[WIDTH-2:0], w_div_ge};

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    rem_d    = rem_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    w_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = op;
          b_d   = b;
          acc_d = {{WIDTH{1'b0}}, a};
          case (op)
            OP_ADD: begin
              state_d  = ST_DONE;
              w_load   = 1'b1;
              result_d = {{(WIDTH-1){1'b0}}, w_add};
              rem_d    = '0;
              carry_d  = w_add[WIDTH];
              err_d    = 1'b0;
            end
            OP_SUB: begin
              state_d  = ST_DONE;
              w_load   = 1'b1;
              result_d = {{WIDTH{1'b0}}, w_sub[WIDTH-1:0]};
              rem_d    = '0;
              carry_d  = w_sub[WIDTH];
              err_d    = 1'b0;
            end
            OP_MUL: begin
              state_d = ST_CALC;
              cnt_d   = CNT_W'(WIDTH);
            end
            default: begin
              if (b == '0) begin
                state_d  = ST_DONE;
                w_load   = 1'b1;
                result_d = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                rem_d    = a;
                carry_d  = 1'b0;
                err_d    = 1'b1;
              end else begin
                state_d = ST_CALC;
                cnt_d   = CNT_W'(WIDTH);
              end
            end
          endcase
        end
      end

      ST_CALC: begin
        acc_d = (op_q == OP_MUL) ? w_mul_next : w_div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          w_load  = 1'b1;
          carry_d = 1'b0;
          err_d   = 1'b0;
          if (op_q == OP_MUL) begin
            result_d = w_mul_next;
            rem_d    = '0;
          end else begin
            result_d = {{WIDTH{1'b0}}, w_div_next[WIDTH-1:0]};
            rem_d    = w_div_next[2*WIDTH-1:WIDTH];
          end
        end
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (w_load) zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign rem    = rem_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign err    = err_q;

`ifdef ALU_SEVSEG_EN
  // Low byte of the next result, zero-padded when the result is narrower.
  logic [7:0] w_res8;
  logic [6:0] w_seg1, w_seg0;
  logic [6:0] disp1_q, disp0_q;

  if (2*WIDTH >= 8) begin : g_res8_wide
    assign w_res8 = result_d[7:0];
  end else begin : g_res8_narrow
    assign w_res8 = {{(8-2*WIDTH){1'b0}}, result_d};
  end

  seg7_dec u_seg1 (.hex_i(w_res8[7:4]), .seg_o(w_seg1));
  seg7_dec u_seg0 (.hex_i(w_res8[3:0]), .seg_o(w_seg0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp1_q <= 7'h3F;
      disp0_q <= 7'h3F;
    end else if (w_load) begin
      disp1_q <= w_seg1;
      disp0_q <= w_seg0;
    end
  end

  assign disp1op = disp1_q;
  assign disp0op = disp0_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_nb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_nb
// Description : Self-checking bench for alu_seq_nb at WIDTH=4. A cycle-level
//               behavioural model predicts handshake and output values every
//               cycle; directed operations add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_nb;
  import alu_seq_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic [W-1:0] rem;
  logic         carry, zero, err;
`ifdef ALU_SEVSEG_EN
  logic [6:0]   disp1op, disp0op;
`endif

  alu_seq_nb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rem(rem), .carry(carry), .zero(zero), .err(err)
`ifdef ALU_SEVSEG_EN
    , .disp1op(disp1op), .disp0op(disp0op)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2*W-1:0] res;
    logic [W-1:0]   rem;
    logic           c;
    logic           z;
    logic           e;
  } exp_t;

  localparam exp_t RST_VAL = '{res: '0, rem: '0, c: 1'b0, z: 1'b1, e: 1'b0};

  function automatic exp_t model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    int   v;
    r = '0;
    case (o)
      OP_ADD: begin
        v = int'(x) + int'(y);
        r.res = (2*W)'(v);
        r.c   = (v >= (1 << W));
      end
      OP_SUB: begin
        v = int'(x) - int'(y);
        r.res = (2*W)'(v & ((1 << W) - 1));
        r.c   = (x < y);
      end
      OP_MUL: r.res = (2*W)'(int'(x) * int'(y));
      default: begin
        if (y == 0) begin
          r.res = (2*W)'((1 << W) - 1);
          r.rem = x;
          r.e   = 1'b1;
        end else begin
          r.res = (2*W)'(int'(x) / int'(y));
          r.rem = W'(int'(x) % int'(y));
        end
      end
    endcase
    r.z = (r.res == 0);
    return r;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [W-1:0] y);
    if (o == OP_MUL || (o == OP_DIV && y != 0)) return W + 1;
    return 1;
  endfunction

  logic m_busy  = 1'b0;
  logic m_valid = 1'b0;
  int   m_wait  = 0;
  exp_t m_exp   = '0;
  exp_t m_shown = RST_VAL;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_wait  <= 0;
      m_shown <= RST_VAL;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_exp  <= model_op(op, a, b);
        if (model_lat(op, b) == 1) begin
          m_valid <= 1'b1;
          m_shown <= model_op(op, a, b);
        end else begin
          m_wait <= model_lat(op, b) - 1;
        end
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
      end
    end else if (m_wait == 1) begin
      m_valid <= 1'b1;
      m_shown <= m_exp;
    end else begin
      m_wait <= m_wait - 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("cmp_in_ready",  in_ready,  !m_busy);
    check("cmp_out_valid", out_valid, m_valid);
    check("cmp_result",    result,    m_shown.res);
    check("cmp_rem",       rem,       m_shown.rem);
    check("cmp_carry",     carry,     m_shown.c);
    check("cmp_zero",      zero,      m_shown.z);
    check("cmp_err",       err,       m_shown.e);
  end

  // ---------------- directed stimulus ----------------
  task automatic do_op(input string nm, input logic [1:0] o, input logic [W-1:0] xa,
                       input logic [W-1:0] xb, input int hold,
                       input logic [2*W-1:0] er, input logic [W-1:0] erem,
                       input logic ec, input logic ez, input logic ee, input int elat);
    int n;
    @(posedge clk); #1;
    a = xa; b = xb; op = o; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    check({nm, "_ready_before"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~xa; b = ~xb; op = ~o;   // later input changes must be ignored
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, elat);
    check({nm, "_result"}, result, er);
    check({nm, "_rem"}, rem, erem);
    check({nm, "_carry"}, carry, ec);
    check({nm, "_zero"}, zero, ez);
    check({nm, "_err"}, err, ee);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        check({nm, "_hold_valid"}, out_valid, 1);
        check({nm, "_hold_in_ready"}, in_ready, 0);
        check({nm, "_hold_result"}, result, er);
        @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    check({nm, "_idle_after"}, in_ready, 1);
    check({nm, "_valid_after"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_zero", zero, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    //     name     op      a   b  hold result rem c  z  e  lat
    do_op("add",    OP_ADD, 15, 1, 0, 8'h10, 0, 1, 0, 0, 1);
    do_op("sub_bw", OP_SUB, 3,  6, 0, 8'h0D, 0, 1, 0, 0, 1);
    do_op("sub_eq", OP_SUB, 5,  5, 0, 8'h00, 0, 0, 1, 0, 1);
    do_op("mul_ff", OP_MUL, 15, 15, 0, 8'hE1, 0, 0, 0, 0, 5);
    do_op("div",    OP_DIV, 14, 4, 0, 8'h03, 2, 0, 0, 0, 5);
    do_op("div0",   OP_DIV, 9,  0, 0, 8'h0F, 9, 0, 0, 1, 1);
    do_op("mul_bp", OP_MUL, 7,  9, 3, 8'h3F, 0, 0, 0, 0, 5);
    do_op("mul_z",  OP_MUL, 0,  5, 0, 8'h00, 0, 0, 1, 0, 5);
    do_op("div_1",  OP_DIV, 15, 1, 2, 8'h0F, 0, 0, 0, 0, 5);
    do_op("div_lt", OP_DIV, 3,  7, 0, 8'h00, 3, 0, 1, 0, 5);

    // Back-to-back requests: in_valid held high, acceptance every other cycle
    @(posedge clk); #1;
    a = 4'd1; b = 4'd2; op = OP_ADD; in_valid = 1'b1; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    op = OP_MUL; a = 4'd3; b = 4'd5;
    repeat (12) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);

    // Reset two cycles into a multiply aborts it
    @(posedge clk); #1;
    a = 4'd7; b = 4'd9; op = OP_MUL; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready_rst", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
    end
    check("abort_in_ready", in_ready, 1);
    check("abort_result", result, 0);
    check("abort_rem", rem, 0);
    check("abort_zero", zero, 1);
    check("abort_carry", carry, 0);
    check("abort_err", err, 0);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
